// File: rtl/mac_unit_parallel_pipe.sv
// rtl/mac_unit_parallel_pipe.sv - parallel dot-product MAC: multipliers, pipelined adder tree, framed accumulator, round/saturate
module mac_unit_parallel_pipe #(
    parameter int DATA_WIDTH   = 8,
    parameter int VEC_LENGTH   = 16,
    parameter int ACC_WIDTH    = 32,
    parameter int RESULT_WIDTH = 16,
    parameter int REG_EVERY    = 2,
    parameter int SHIFT_WIDTH  = 5
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   en,
    input  logic                                   in_valid,
    input  logic                                   in_first,
    input  logic                                   in_last,
    input  logic                                   load_prev,
    input  logic                                   act_signed,
    input  logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0]  act_in,
    input  logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0]  w_in,
    input  logic [ACC_WIDTH-1:0]                   accum_prev,
    input  logic [SHIFT_WIDTH-1:0]                 out_shift,
    output logic                                   out_valid,
    output logic [RESULT_WIDTH-1:0]                result,
    output logic [ACC_WIDTH-1:0]                   acc_out,
    output logic                                   out_sat
);

    localparam int T      = $clog2(VEC_LENGTH);
    localparam int PROD_W = 2 * DATA_WIDTH + 1;
    localparam int SUM_W  = PROD_W + T;
    localparam int R      = (T + REG_EVERY - 1) / REG_EVERY;
    localparam int HI_W   = ACC_WIDTH - RESULT_WIDTH + 2;

    typedef struct packed {
        logic                   valid;
        logic                   first;
        logic                   last;
        logic                   load_prev;
        logic [ACC_WIDTH-1:0]   accum_prev;
        logic [SHIFT_WIDTH-1:0] shift;
    } side_t;

    // Activation is zero- or sign-extended; the product always fits in PROD_W bits.
    function automatic logic signed [PROD_W-1:0] lane_mul(
        input logic [DATA_WIDTH-1:0] a,
        input logic [DATA_WIDTH-1:0] w,
        input logic                  a_signed
    );
        logic signed [PROD_W-1:0] a_ext;
        logic signed [PROD_W-1:0] w_ext;
        a_ext = {{(PROD_W-DATA_WIDTH){a_signed & a[DATA_WIDTH-1]}}, a};
        w_ext = {{(PROD_W-DATA_WIDTH){w[DATA_WIDTH-1]}}, w};
        return a_ext * w_ext;
    endfunction

    side_t                    sb_q [0:R];
    logic signed [PROD_W-1:0] prod_q [VEC_LENGTH];
    // Heap-ordered adder tree: node 1 is the root, leaves are VEC_LENGTH..2*VEC_LENGTH-1.
    logic signed [SUM_W-1:0]  node [1:2*VEC_LENGTH-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k <= R; k++) sb_q[k] <= '0;
            for (int i = 0; i < VEC_LENGTH; i++) prod_q[i] <= '0;
        end else if (en) begin
            sb_q[0].valid      <= in_valid;
            sb_q[0].first      <= in_first;
            sb_q[0].last       <= in_last;
            sb_q[0].load_prev  <= load_prev;
            sb_q[0].accum_prev <= accum_prev;
            sb_q[0].shift      <= out_shift;
            for (int k = 1; k <= R; k++) sb_q[k] <= sb_q[k-1];
            for (int i = 0; i < VEC_LENGTH; i++)
                prod_q[i] <= lane_mul(act_in[i], w_in[i], act_signed);
        end
    end

    for (genvar i = 0; i < VEC_LENGTH; i++) begin : g_leaf
        assign node[VEC_LENGTH+i] = SUM_W'(prod_q[i]);
    end

    for (genvar l = 1; l <= T; l++) begin : g_lvl
        for (genvar i = 0; i < (VEC_LENGTH >> l); i++) begin : g_node
            localparam int N = (VEC_LENGTH >> l) + i;
            logic signed [SUM_W-1:0] s;
            assign s = node[2*N] + node[2*N+1];
            if ((l % REG_EVERY) == 0 || l == T) begin : g_reg
                logic signed [SUM_W-1:0] q;
                always_ff @(posedge clk) begin
                    if (reset)   q <= '0;
                    else if (en) q <= s;
                end
                assign node[N] = q;
            end else begin : g_comb
                assign node[N] = s;
            end
        end
    end

    logic                    acc_fire;
    logic [SHIFT_WIDTH-1:0]  acc_shift;
    logic [ACC_WIDTH-1:0]    acc_q;
    logic [ACC_WIDTH-1:0]    acc_base;
    logic signed [ACC_WIDTH-1:0] sum_ext;

    assign sum_ext = ACC_WIDTH'(node[1]);

    always_comb begin
        acc_base = acc_q;
        if (sb_q[R].first) acc_base = sb_q[R].load_prev ? sb_q[R].accum_prev : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q     <= '0;
            acc_fire  <= 1'b0;
            acc_shift <= '0;
        end else if (en) begin
            acc_fire  <= sb_q[R].valid & sb_q[R].last;
            acc_shift <= sb_q[R].shift;
            if (sb_q[R].valid) acc_q <= acc_base + sum_ext;
        end
    end

    // One guard bit keeps the rounding add from wrapping near the accumulator limits.
    logic [ACC_WIDTH:0]          rnd;
    logic signed [ACC_WIDTH:0]   rsum;
    logic signed [ACC_WIDTH:0]   rshift;
    logic [HI_W-1:0]             hi;
    logic                        clip;
    logic [RESULT_WIDTH-1:0]     sat_val;

    always_comb begin
        rnd     = ({{ACC_WIDTH{1'b0}}, 1'b1} << acc_shift) >> 1;
        rsum    = $signed({acc_q[ACC_WIDTH-1], acc_q}) + $signed(rnd);
        rshift  = rsum >>> acc_shift;
        hi      = rshift[ACC_WIDTH:RESULT_WIDTH-1];
        clip    = (hi != {HI_W{rshift[ACC_WIDTH]}});
        sat_val = rshift[RESULT_WIDTH-1:0];
        if (clip)
            sat_val = rshift[ACC_WIDTH] ? {1'b1, {(RESULT_WIDTH-1){1'b0}}}
                                        : {1'b0, {(RESULT_WIDTH-1){1'b1}}};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            result    <= '0;
            acc_out   <= '0;
            out_sat   <= 1'b0;
        end else if (en) begin
            out_valid <= acc_fire;
            if (acc_fire) begin
                result  <= sat_val;
                acc_out <= acc_q;
                out_sat <= clip;
            end
        end
    end

endmodule

// File: tb/tb_mac_unit_parallel_pipe.sv
// tb/tb_mac_unit_parallel_pipe.sv - self-checking bench for mac_unit_parallel_pipe
module tb_mac_unit_parallel_pipe;

    localparam int DW = 8;
    localparam int VL = 16;
    localparam int AW = 32;
    localparam int RW = 16;
    localparam int SW = 5;

    logic                    clk;
    logic                    reset;
    logic                    en;
    logic                    in_valid;
    logic                    in_first;
    logic                    in_last;
    logic                    load_prev;
    logic                    act_signed;
    logic [VL-1:0][DW-1:0]   act_in;
    logic [VL-1:0][DW-1:0]   w_in;
    logic [AW-1:0]           accum_prev;
    logic [SW-1:0]           out_shift;
    logic                    out_valid;
    logic [RW-1:0]           result;
    logic [AW-1:0]           acc_out;
    logic                    out_sat;

    mac_unit_parallel_pipe #(
        .DATA_WIDTH(DW), .VEC_LENGTH(VL), .ACC_WIDTH(AW),
        .RESULT_WIDTH(RW), .REG_EVERY(2), .SHIFT_WIDTH(SW)
    ) dut (
        .clk(clk), .reset(reset), .en(en), .in_valid(in_valid),
        .in_first(in_first), .in_last(in_last), .load_prev(load_prev),
        .act_signed(act_signed), .act_in(act_in), .w_in(w_in),
        .accum_prev(accum_prev), .out_shift(out_shift),
        .out_valid(out_valid), .result(result), .acc_out(acc_out), .out_sat(out_sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] acc;
        logic [RW-1:0] res;
        logic          sat;
        int            cyc;
    } out_t;

    typedef struct {
        int            nb;
        logic [DW-1:0] a;
        logic [DW-1:0] w;
        logic          lane0;
        logic          sgn;
        logic [SW-1:0] sh;
        logic          lp;
        logic [AW-1:0] prev;
        int            e_acc;
        int            e_res;
        logic          e_sat;
    } vec_t;

    out_t          exp_q[$];
    out_t          got_q[$];
    vec_t          tbl[9];
    int            checks = 0;
    int            failures = 0;
    int            cyc = 0;
    logic [AW-1:0] m_acc = '0;
    logic [VL-1:0][DW-1:0] ra, rw;

    task automatic chk(input string nm, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", nm, got, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        cyc++;
        if (en && out_valid) got_q.push_back('{acc_out, result, out_sat, cyc});
    endtask

    function automatic longint beat_sum(input logic [VL-1:0][DW-1:0] a,
                                        input logic [VL-1:0][DW-1:0] w, input logic s);
        longint t = 0;
        for (int i = 0; i < VL; i++) begin
            longint av = s ? longint'($signed(a[i])) : longint'(a[i]);
            t += av * longint'($signed(w[i]));
        end
        return t;
    endfunction

    function automatic out_t model_out(input logic [AW-1:0] acc, input logic [SW-1:0] sh);
        out_t   o;
        longint r;
        r = (longint'($signed(acc)) + ((sh == 0) ? 64'sd0 : (64'sd1 << (sh - 1)))) >>> sh;
        o.acc = acc;
        o.cyc = 0;
        o.sat = 1'b0;
        if (r > 32767) begin
            o.res = 16'h7fff; o.sat = 1'b1;
        end else if (r < -32768) begin
            o.res = 16'h8000; o.sat = 1'b1;
        end else begin
            o.res = r[15:0];
        end
        return o;
    endfunction

    task automatic beat(input logic v, input logic f, input logic l, input logic lp,
                        input logic s, input logic [AW-1:0] prev, input logic [SW-1:0] sh,
                        input logic [VL-1:0][DW-1:0] a, input logic [VL-1:0][DW-1:0] w);
        longint sum;
        en = 1'b1; in_valid = v; in_first = f; in_last = l; load_prev = lp;
        act_signed = s; accum_prev = prev; out_shift = sh; act_in = a; w_in = w;
        if (v) begin
            sum = beat_sum(a, w, s);
            if (f) m_acc = lp ? prev : '0;
            m_acc = m_acc + sum[AW-1:0];
            if (l) exp_q.push_back(model_out(m_acc, sh));
        end
        cycle();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) beat(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0, '0);
    endtask

    task automatic stall();
        en = 1'b0; in_valid = 1'($urandom); in_first = 1'($urandom); in_last = 1'($urandom);
        load_prev = 1'($urandom); accum_prev = $urandom; out_shift = SW'($urandom);
        act_in = {$urandom, $urandom, $urandom, $urandom};
        w_in   = {$urandom, $urandom, $urandom, $urandom};
        cycle();
    endtask

    task automatic compare_model(input string nm);
        chk({nm, "_count"}, got_q.size(), exp_q.size());
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            out_t g, e;
            g = got_q.pop_front();
            e = exp_q.pop_front();
            chk({nm, "_acc"}, longint'($signed(g.acc)), longint'($signed(e.acc)));
            chk({nm, "_res"}, longint'($signed(g.res)), longint'($signed(e.res)));
            chk({nm, "_sat"}, g.sat, e.sat);
        end
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        int   c0;
        out_t g;
        logic [VL-1:0][DW-1:0] a, w;

        tbl[0] = '{1, 8'd1,   8'd1,   1'b0, 1'b1, 5'd0, 1'b0, 32'd0,    16,       16,     1'b0};
        tbl[1] = '{4, 8'd127, 8'h80,  1'b0, 1'b1, 5'd8, 1'b0, 32'd0,    -1040384, -4064,  1'b0};
        tbl[2] = '{1, 8'd1,   8'd1,   1'b0, 1'b1, 5'd0, 1'b1, 32'd1000, 1016,     1016,   1'b0};
        tbl[3] = '{1, 8'd127, 8'd127, 1'b0, 1'b1, 5'd0, 1'b0, 32'd0,    258064,   32767,  1'b1};
        tbl[4] = '{1, 8'd127, 8'h81,  1'b0, 1'b1, 5'd0, 1'b0, 32'd0,    -258064,  -32768, 1'b1};
        tbl[5] = '{1, 8'hff,  8'd2,   1'b0, 1'b0, 5'd0, 1'b0, 32'd0,    8160,     8160,   1'b0};
        tbl[6] = '{1, 8'hff,  8'd2,   1'b0, 1'b1, 5'd0, 1'b0, 32'd0,    -32,      -32,    1'b0};
        tbl[7] = '{1, 8'd3,   8'd1,   1'b1, 1'b1, 5'd1, 1'b0, 32'd0,    3,        2,      1'b0};
        tbl[8] = '{1, 8'd3,   8'hff,  1'b1, 1'b1, 5'd1, 1'b0, 32'd0,    -3,       -1,     1'b0};

        reset = 1'b1; en = 1'b1; in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
        load_prev = 1'b0; act_signed = 1'b0; act_in = '0; w_in = '0;
        accum_prev = '0; out_shift = '0;
        for (int k = 0; k < 3; k++) cycle();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_result", result, 0);
        chk("rst_acc_out", acc_out, 0);
        chk("rst_out_sat", out_sat, 0);
        reset = 1'b0;
        got_q.delete();

        for (int t = 0; t < 9; t++) begin
            got_q.delete();
            for (int i = 0; i < VL; i++) begin
                a[i] = (tbl[t].lane0 && i != 0) ? '0 : tbl[t].a;
                w[i] = (tbl[t].lane0 && i != 0) ? '0 : tbl[t].w;
            end
            for (int b = 0; b < tbl[t].nb; b++)
                beat(1'b1, b == 0, b == tbl[t].nb - 1, tbl[t].lp, tbl[t].sgn,
                     tbl[t].prev, tbl[t].sh, a, w);
            idle(8);
            chk($sformatf("vec%0d_count", t), got_q.size(), 1);
            if (got_q.size() > 0) begin
                g = got_q[0];
                chk($sformatf("vec%0d_acc", t), longint'($signed(g.acc)), tbl[t].e_acc);
                chk($sformatf("vec%0d_res", t), longint'($signed(g.res)), tbl[t].e_res);
                chk($sformatf("vec%0d_sat", t), g.sat, tbl[t].e_sat);
            end
        end
        exp_q.delete();
        got_q.delete();

        a = '0; w = '0;
        for (int i = 0; i < VL; i++) begin a[i] = 8'd1; w[i] = 8'd1; end
        c0 = cyc;
        beat(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, '0, '0, a, w);
        idle(8);
        chk("latency_count", got_q.size(), 1);
        if (got_q.size() > 0) chk("latency", got_q[0].cyc - c0, 5);
        compare_model("latency_val");

        for (int i = 0; i < VL; i++) begin a[i] = DW'(i + 1); w[i] = 8'hfd; end
        c0 = cyc;
        beat(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, '0, 5'd2, a, w);
        stall(); stall(); stall();
        beat(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, '0, 5'd2, a, w);
        idle(10);
        chk("stall_count", got_q.size(), 1);
        if (got_q.size() > 0) chk("stall_latency", got_q[0].cyc - c0, 9);
        compare_model("stall_val");

        beat(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, '0, '0, a, w);
        idle(4);
        chk("hold_pre", out_valid, 1);
        stall();
        chk("hold_1", out_valid, 1);
        stall();
        chk("hold_2", out_valid, 1);
        idle(1);
        chk("hold_drop", out_valid, 0);
        compare_model("hold_val");

        beat(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, '0, '0, a, w);
        idle(1);
        reset = 1'b1; en = 1'b0;
        cycle();
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_result", result, 0);
        chk("mid_rst_acc_out", acc_out, 0);
        chk("mid_rst_out_sat", out_sat, 0);
        reset = 1'b0;
        exp_q.delete();
        got_q.delete();
        m_acc = '0;
        idle(10);
        chk("mid_rst_no_output", got_q.size(), 0);
        got_q.delete();

        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 7) == 0) begin
                stall();
            end else begin
                ra = {$urandom, $urandom, $urandom, $urandom};
                rw = {$urandom, $urandom, $urandom, $urandom};
                beat($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                     $urandom_range(0, 2) == 0, 1'($urandom), 1'($urandom),
                     $urandom, SW'($urandom_range(0, 12)), ra, rw);
            end
        end
        idle(8);
        compare_model("rand");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mac_unit_parallel_pipe.md
Name: mac_unit_parallel_pipe

Overview:
- Next-generation parallel dot-product MAC for the BitSim PE array. Each beat takes VEC_LENGTH activation/weight pairs.
- Datapath: registered multipliers, then a pipelined adder tree with a parametrised register spacing, then a framed accumulator (first/last flags), then a rounding/saturating output stage.
- Generalises the fixed 8-lane unit: arbitrary power-of-two lane count, configurable pipeline depth, valid tracking, unsigned-activation mode, runtime output scaling.

Parameters:
- DATA_WIDTH, 8: activation and weight width.
- VEC_LENGTH, 16: lanes per beat. Power of two, ≥2.
- ACC_WIDTH, 32: accumulator width. Must be ≥ 2*DATA_WIDTH+1+log2(VEC_LENGTH).
- RESULT_WIDTH, 16: output width. Signed, saturated.
- REG_EVERY, 2: adder-tree levels between pipeline registers. Must be ≥1.
- SHIFT_WIDTH, 5: width of out_shift.

Ports:
- clk, input, 1: clock.
- reset, input, 1: synchronous, active-high reset.
- en, input, 1: global pipeline enable. When low, every register holds.
- in_valid, input, 1: input beat valid.
- in_first, input, 1: beat starts a new accumulation.
- in_last, input, 1: beat ends the accumulation and produces a result.
- load_prev, input, 1: with in_first, seed the accumulator from accum_prev instead of 0.
- act_signed, input, 1: 1 = activations signed; 0 = activations unsigned. Weights are always signed.
- act_in, input, [VEC_LENGTH][DATA_WIDTH]: activations.
- w_in, input, [VEC_LENGTH][DATA_WIDTH]: signed weights.
- accum_prev, input, ACC_WIDTH: signed seed value.
- out_shift, input, SHIFT_WIDTH: arithmetic right shift applied to the result.
- out_valid, output, 1: result valid, one cycle per framed accumulation.
- result, output, RESULT_WIDTH: rounded, saturated result.
- acc_out, output, ACC_WIDTH: raw accumulator snapshot taken with the result.
- out_sat, output, 1: result was clipped.

Behaviour:
- Reset: every pipeline register, valid bit and the accumulator clear to 0. out_valid=0, result=0, acc_out=0, out_sat=0. Reset dominates en.
- Reset mid-frame: all in-flight beats are discarded and no out_valid is produced for them.
- Side-band capture: control flags, act_signed, load_prev, accum_prev and out_shift are captured with their beat and pipelined alongside it. Later changes never affect an in-flight beat.
- Stage M (1 cycle): per-lane product of (act sign- or zero-extended per act_signed) and signed w. Product width is 2*DATA_WIDTH+1; the product is registered.
- Tree stage:
  - T = log2(VEC_LENGTH) pairwise levels; each level grows the sum by 1 bit.
  - A register follows every REG_EVERY levels; the final level is always registered.
  - Tree register count R = ceil(T/REG_EVERY). Defaults: T=4, R=2.
- Accumulator stage (1 cycle), valid beats only, sum sign-extended to ACC_WIDTH:
  - in_first=1: acc = (load_prev ? accum_prev : 0) + sum.
  - otherwise: acc = acc + sum.
  - Accumulation wraps modulo 2^ACC_WIDTH.
  - Invalid beats leave acc unchanged.
- Output stage (1 cycle), on a valid beat with in_last=1:
  - Round: r = (acc + (out_shift>0 ? 1<<(out_shift-1) : 0)) >>> out_shift. This is round-half-up.
  - Saturate r to the signed RESULT_WIDTH range; out_sat=1 if clipped.
  - out_valid pulses high for exactly one enabled cycle. result, acc_out and out_sat hold until the next out_valid.
- Latency: a beat with in_last presented at enabled cycle 0 gives out_valid at enabled cycle R+3 (default 5).
- Throughput: one beat per enabled cycle. There is no backpressure.
- in_first and in_last on the same beat form a single-beat frame.
- Frame boundaries:
  - A beat without in_first after an in_last continues from the retained acc.
  - A beat with in_first mid-frame restarts the frame and discards the prior partial sum silently.
- en low: pipeline freezes and out_valid is held at its current value. Cycle counts in this spec are in enabled cycles.

Test Plan:
- Single-beat frame, all act=1, w=1, shift=0, signed: out_valid exactly 5 cycles later, result=16, acc_out=16, out_sat=0.
- 4-beat frame, act=127, w=-128 on all lanes, shift=8: acc_out=-1040384, result=-4064, out_sat=0. Back-to-back second frame with load_prev=1, accum_prev=1000, one beat of act=1, w=1: acc_out=1016.
- Saturation, act=127, w=127, single beat, shift=0: acc_out=258064, result=32767, out_sat=1. Same frame with w=-127: result=-32768, out_sat=1.
- act=0xFF, w=2 on all lanes: act_signed=0 gives result=8160; act_signed=1 gives result=-32.
- Rounding, lane0 act=3, w=1, others 0: shift=1 gives result=2; sum=-3, shift=1 gives result=-1.
- Stall/reset: drop en for 3 cycles mid-frame, then out_valid is delayed exactly 3 cycles with an unchanged result. Assert reset two cycles after in_last: no out_valid, and all outputs are 0 the next cycle.
